// File: rtl/fetch_queue_if.sv
// Bundle of the memory-side request/response signals, the redirect inputs and the
// decode-side valid/ready handshake used by the instruction prefetch queue.
// The master modport is the prefetch queue. The slave modport is the surrounding
// system, which is the memory plus the branch unit plus the decode stage.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          mem_en;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_data_in;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          instr_valid;
  logic [31:0]   instr_out;
  logic [31:0]   instr_pc;
  logic          instr_ready;
  logic [CW-1:0] count;

  modport master (
    output mem_en,
    output mem_addr,
    input  mem_data_in,
    input  redirect_valid,
    input  redirect_pc,
    output instr_valid,
    output instr_out,
    output instr_pc,
    input  instr_ready,
    output count
  );

  modport slave (
    input  mem_en,
    input  mem_addr,
    output mem_data_in,
    output redirect_valid,
    output redirect_pc,
    input  instr_valid,
    input  instr_out,
    input  instr_pc,
    output instr_ready,
    input  count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue sitting between main memory and the IF/ID stage.
// It issues sequential word fetches with a fixed one-cycle memory latency.
// Returned words are buffered together with their PCs in a small circular queue.
// Entries are handed to decode over a valid/ready handshake.
// A redirect flushes the queue, drops any response still in flight, and restarts
// fetching at the new word-aligned PC.
// The fetch engine only issues when a free slot is guaranteed for the response.
// It counts buffered entries plus the outstanding request, and takes no credit
// for a pop in the same cycle. As a result the queue can never overflow.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic           clk,
  input logic           reset,
  fetch_queue_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]   LP_DEPTH   = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] LP_CNT_ONE = CW'(1);
  localparam logic [PW-1:0] LP_PTR_ONE = PW'(1);

  logic [31:0]   r_fetchPc;
  logic [31:0]   r_respPc;
  logic          r_inflight;
  logic [PW-1:0] r_rdPtr;
  logic [PW-1:0] r_wrPtr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_instrMem [DEPTH];
  logic [31:0]   r_pcMem    [DEPTH];

  logic [CW:0]   w_occupancy;
  logic          w_memEn;
  logic          w_instrValid;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_redirectPc;

  // The outstanding request counts against capacity exactly like a stored entry.
  assign w_occupancy  = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};

  // Issue only when a free slot is guaranteed. Reset low and redirect cycles never issue.
  assign w_memEn      = reset & ~bus.redirect_valid & (w_occupancy < LP_DEPTH);

  // A redirect hides the head so that decode cannot consume a stale instruction.
  assign w_instrValid = (r_count != '0) & ~bus.redirect_valid;

  assign w_push       = r_inflight;
  assign w_pop        = w_instrValid & bus.instr_ready;
  assign w_redirectPc = bus.redirect_pc & ~32'h0000_0003;

  assign bus.mem_en      = w_memEn;
  assign bus.mem_addr    = reset ? r_fetchPc : 32'h0000_0000;
  assign bus.instr_valid = w_instrValid;
  assign bus.instr_out   = r_instrMem[r_rdPtr];
  assign bus.instr_pc    = r_pcMem[r_rdPtr];
  assign bus.count       = r_count;

  // Control state: fetch PC, the in-flight tracker, the queue pointers and the occupancy count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetchPc  <= RESET_PC;
      r_respPc   <= 32'h0000_0000;
      r_inflight <= 1'b0;
      r_rdPtr    <= '0;
      r_wrPtr    <= '0;
      r_count    <= '0;
    end else if (bus.redirect_valid) begin
      r_fetchPc  <= w_redirectPc;
      r_inflight <= 1'b0;
      r_rdPtr    <= '0;
      r_wrPtr    <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_memEn;
      r_respPc   <= r_fetchPc;
      if (w_memEn) begin
        r_fetchPc <= r_fetchPc + 32'd4;
      end
      if (w_push) begin
        r_wrPtr <= r_wrPtr + LP_PTR_ONE;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + LP_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LP_CNT_ONE;
        2'b01:   r_count <= r_count - LP_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage: write the returning word and its PC unless a redirect is killing it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_instrMem[i] <= 32'h0000_0000;
        r_pcMem[i]    <= 32'h0000_0000;
      end
    end else if (w_push && !bus.redirect_valid) begin
      r_instrMem[r_wrPtr] <= bus.mem_data_in;
      r_pcMem[r_wrPtr]    <= r_respPc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for the instruction prefetch queue.
// A one-cycle memory returns (address ^ A5A5_0000) for each request.
// Outputs are checked every cycle against a queue-based reference model.
// The stimulus combines directed scenarios with a randomized stretch.
// A second instance with a wrapping reset PC checks address wrap-around.
module tb_fetch_queue;

  localparam int          DEPTH   = 4;
  localparam logic [31:0] MEM_KEY = 32'hA5A5_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic clk;
  logic reset;

  int checks;
  int failures;

  fetch_queue_if #(.DEPTH(DEPTH)) fq ();
  fetch_queue_if #(.DEPTH(DEPTH)) fqWrap ();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (fq)
  );

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(WRAP_PC)) dutWrap (
    .clk   (clk),
    .reset (reset),
    .bus   (fqWrap)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-cycle memory: the data presented this cycle answers last cycle's address.
  logic [31:0] memLastAddr;
  logic [31:0] memLastAddrWrap;
  always @(posedge clk) begin
    memLastAddr     <= fq.mem_addr;
    memLastAddrWrap <= fqWrap.mem_addr;
  end
  assign fq.mem_data_in     = memLastAddr ^ MEM_KEY;
  assign fqWrap.mem_data_in = memLastAddrWrap ^ MEM_KEY;

  // Reference model. It keeps a queue of buffered PCs, the next fetch PC and at
  // most one outstanding request.
  logic [31:0] modelQ [$];
  logic [31:0] modelFetchPc;
  bit          modelPending;
  logic [31:0] modelPendPc;

  // Compare one observed value against its expected value and report a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // Return the model to its post-reset state.
  task automatic resetModel(input logic [31:0] pc);
    modelQ.delete();
    modelFetchPc = pc;
    modelPending = 0;
    modelPendPc  = 32'h0;
  endtask

  // Apply one cycle of inputs, check the outputs, then advance the model across the clock edge.
  task automatic applyStimulus(input logic ready, input logic redir, input logic [31:0] rpc);
    logic expMemEn;
    logic expValid;
    int   inFlight;
    fq.instr_ready    = ready;
    fq.redirect_valid = redir;
    fq.redirect_pc    = rpc;
    #1;
    inFlight = modelPending ? 1 : 0;
    expMemEn = !redir && ((modelQ.size() + inFlight) < DEPTH);
    expValid = !redir && (modelQ.size() != 0);
    checkOutput("mem_en", 32'(fq.mem_en), 32'(expMemEn));
    if (expMemEn) checkOutput("mem_addr", fq.mem_addr, modelFetchPc);
    checkOutput("instr_valid", 32'(fq.instr_valid), 32'(expValid));
    checkOutput("count", 32'(fq.count), 32'(modelQ.size()));
    if (expValid) begin
      checkOutput("instr_pc", fq.instr_pc, modelQ[0]);
      checkOutput("instr_out", fq.instr_out, modelQ[0] ^ MEM_KEY);
    end
    if (redir) begin
      modelQ.delete();
      modelPending = 0;
      modelFetchPc = rpc & ~32'h3;
    end else begin
      if (expValid && ready) void'(modelQ.pop_front());
      if (modelPending) modelQ.push_back(modelPendPc);
      modelPending = expMemEn;
      modelPendPc  = modelFetchPc;
      if (expMemEn) modelFetchPc = modelFetchPc + 32'd4;
    end
    @(negedge clk);
  endtask

  // Directed scenarios followed by a randomized run.
  initial begin
    logic [31:0] wrapAddrs [4];
    checks   = 0;
    failures = 0;
    wrapAddrs[0] = 32'hFFFF_FFF8;
    wrapAddrs[1] = 32'hFFFF_FFFC;
    wrapAddrs[2] = 32'h0000_0000;
    wrapAddrs[3] = 32'h0000_0004;

    reset                 = 1'b0;
    fq.instr_ready        = 1'b0;
    fq.redirect_valid     = 1'b0;
    fq.redirect_pc        = 32'h0;
    fqWrap.instr_ready    = 1'b0;
    fqWrap.redirect_valid = 1'b0;
    fqWrap.redirect_pc    = 32'h0;
    repeat (2) @(negedge clk);

    checkOutput("rst_mem_en", 32'(fq.mem_en), 32'h0);
    checkOutput("rst_instr_valid", 32'(fq.instr_valid), 32'h0);
    checkOutput("rst_count", 32'(fq.count), 32'h0);
    checkOutput("rst_mem_addr", fq.mem_addr, 32'h0);
    checkOutput("rst_instr_out", fq.instr_out, 32'h0);
    checkOutput("rst_instr_pc", fq.instr_pc, 32'h0);
    checkOutput("rst_wrap_mem_addr", fqWrap.mem_addr, 32'h0);

    // Scenario 1: fill with the consumer stalled.
    reset = 1'b1;
    #1;
    resetModel(32'h0);
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        checkOutput("wrap_mem_en", 32'(fqWrap.mem_en), 32'h1);
        checkOutput("wrap_mem_addr", fqWrap.mem_addr, wrapAddrs[i]);
      end
      applyStimulus(1'b0, 1'b0, 32'h0);
    end
    checkOutput("fill_count", 32'(fq.count), 32'd4);

    // Scenario 2: drain with the consumer always ready.
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 32'h0);

    // Scenario 3: refill, then redirect while the queue is full.
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0100);
    #1;
    checkOutput("redir_count", 32'(fq.count), 32'h0);
    checkOutput("redir_addr", fq.mem_addr, 32'h0000_0100);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 32'h0);

    // Scenario 4: unaligned redirect, then back-to-back redirects.
    applyStimulus(1'b1, 1'b1, 32'h0000_0103);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h0000_2000);
    applyStimulus(1'b1, 1'b1, 32'h0000_3006);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 32'h0);

    // Randomized traffic with sporadic redirects to arbitrary PCs.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 4) != 0, ($urandom % 16) == 0, $urandom);
    end

    // Scenario 6: assert reset between clock edges with a partly filled queue.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_mem_en", 32'(fq.mem_en), 32'h0);
    checkOutput("async_instr_valid", 32'(fq.instr_valid), 32'h0);
    checkOutput("async_count", 32'(fq.count), 32'h0);
    checkOutput("async_mem_addr", fq.mem_addr, 32'h0);
    fq.instr_ready    = 1'b0;
    fq.redirect_valid = 1'b0;
    resetModel(32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("restart_mem_en", 32'(fq.mem_en), 32'h1);
    checkOutput("restart_mem_addr", fq.mem_addr, 32'h0);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(($urandom % 3) != 0, ($urandom % 20) == 0, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
